// File: rtl/frame_pkg.sv
// Shared definitions for the frame packager.
// Holds the two-state FSM encoding and the default frame geometry
// (320x240 pixels) and interface widths used as parameter defaults.
package frame_pkg;

  typedef enum logic {
    SYNC  = 1'b0,  // no valid header yet; incoming pixels are discarded
    WRITE = 1'b1   // header accepted; incoming pixels are stored
  } state_t;

  localparam int FRAME_WIDTH      = 320;
  localparam int FRAME_HEIGHT     = 240;
  localparam int DEF_FRAME_PIXELS = FRAME_WIDTH * FRAME_HEIGHT;

  localparam int DEF_PIXEL_W   = 8;
  localparam int DEF_IN_ADDR_W = 24;
  localparam int DEF_OFS_W     = 17;
  localparam int DEF_DROP_W    = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (clears the count)
//   inc   - add one to the count this cycle
//   count - current count, sticks at all-ones once reached
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    if (v == {WIDTH{1'b1}}) return v;
    return v + WIDTH'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/frame_packager_pp.sv
// Frame packager with ping-pong banks.
// Accepts a header offset followed by a pixel stream and turns it into BRAM
// writes addressed {bank, offset}. The write bank flips each time the last
// pixel of a frame is written; disp_bank then names the bank that was just
// completed so the readout side can display it.
// Ports:
//   clk, rst_n                - clock, asynchronous active-low reset
//   addr_axiiv / addr_axiid   - header valid / header start offset
//   pixel_axiiv / pixel_axiid - pixel valid / pixel data
//   axiov, addr_axiod, pixel_axiod - registered BRAM write port
//   disp_bank  - bank holding the last completed frame
//   frame_done - one-cycle pulse with the write of the last frame pixel
//   addr_err   - one-cycle pulse after an out-of-range header
//   drop_count - saturating count of discarded pixels
module frame_packager_pp
  import frame_pkg::*;
#(
  parameter int PIXEL_W      = DEF_PIXEL_W,
  parameter int IN_ADDR_W    = DEF_IN_ADDR_W,
  parameter int OFS_W        = DEF_OFS_W,
  parameter int FRAME_PIXELS = DEF_FRAME_PIXELS,
  parameter int DROP_W       = DEF_DROP_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 addr_axiiv,
  input  logic [IN_ADDR_W-1:0] addr_axiid,
  input  logic                 pixel_axiiv,
  input  logic [PIXEL_W-1:0]   pixel_axiid,
  output logic                 axiov,
  output logic [OFS_W:0]       addr_axiod,
  output logic [PIXEL_W-1:0]   pixel_axiod,
  output logic                 disp_bank,
  output logic                 frame_done,
  output logic                 addr_err,
  output logic [DROP_W-1:0]    drop_count
);

  // Header range check runs at the full header width so that large offsets
  // such as 0x100000 are rejected instead of aliasing into the frame.
  localparam logic [IN_ADDR_W-1:0] HDR_LIMIT = IN_ADDR_W'(FRAME_PIXELS);
  localparam logic [OFS_W-1:0]     LAST_OFS  = OFS_W'(FRAME_PIXELS - 1);

  state_t             state;
  logic [OFS_W-1:0]   cursor;
  logic               wr_bank;

  logic               hdr_ok;
  logic               hdr_bad;
  state_t             state_nxt;
  logic [OFS_W-1:0]   cursor_eff;
  logic               do_write;
  logic               do_drop;

  // A header in the same cycle as a pixel takes effect first, so the pixel
  // sees the post-header state and offset.
  always_comb begin
    hdr_ok     = addr_axiiv && (addr_axiid < HDR_LIMIT);
    hdr_bad    = addr_axiiv && !hdr_ok;
    state_nxt  = state;
    cursor_eff = cursor;
    if (hdr_ok) begin
      state_nxt  = WRITE;
      cursor_eff = addr_axiid[OFS_W-1:0];
    end else if (hdr_bad) begin
      state_nxt  = SYNC;
    end
    do_write = pixel_axiiv && (state_nxt == WRITE);
    do_drop  = pixel_axiiv && (state_nxt == SYNC);
  end

  // Stage p0 -> p1: registered write port, status pulses and FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SYNC;
      cursor      <= '0;
      wr_bank     <= 1'b0;
      axiov       <= 1'b0;
      addr_axiod  <= '0;
      pixel_axiod <= '0;
      disp_bank   <= 1'b0;
      frame_done  <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cursor     <= cursor_eff;
      axiov      <= do_write;
      frame_done <= 1'b0;
      addr_err   <= hdr_bad;
      if (do_write) begin
        addr_axiod  <= {wr_bank, cursor_eff};
        pixel_axiod <= pixel_axiid;
        if (cursor_eff == LAST_OFS) begin
          // Last pixel of the frame: publish this bank and start the other.
          cursor     <= '0;
          wr_bank    <= ~wr_bank;
          disp_bank  <= wr_bank;
          frame_done <= 1'b1;
        end else begin
          cursor <= cursor_eff + OFS_W'(1);
        end
      end
    end
  end

  sat_counter #(
    .WIDTH (DROP_W)
  ) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (do_drop),
    .count (drop_count)
  );

endmodule

// File: tb/tb_frame_packager_pp.sv
module tb_frame_packager_pp;

  localparam int PIXEL_W      = 8;
  localparam int IN_ADDR_W    = 24;
  localparam int OFS_W        = 17;
  localparam int FRAME_PIXELS = 76800;
  localparam int DROP_W       = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 addr_axiiv;
  logic [IN_ADDR_W-1:0] addr_axiid;
  logic                 pixel_axiiv;
  logic [PIXEL_W-1:0]   pixel_axiid;

  logic                 axiov;
  logic [OFS_W:0]       addr_axiod;
  logic [PIXEL_W-1:0]   pixel_axiod;
  logic                 disp_bank;
  logic                 frame_done;
  logic                 addr_err;
  logic [DROP_W-1:0]    drop_count;

  logic                 s_axiov;
  logic [OFS_W:0]       s_addr_axiod;
  logic [PIXEL_W-1:0]   s_pixel_axiod;
  logic                 s_disp_bank;
  logic                 s_frame_done;
  logic                 s_addr_err;
  logic [3:0]           s_drop_count;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_drop = 0;

  // {axiov, addr_axiod, pixel_axiod, frame_done}
  logic [OFS_W+PIXEL_W+2:0] got_w, exp_w;

  always #5 clk = ~clk;

  frame_packager_pp #(
    .PIXEL_W(PIXEL_W), .IN_ADDR_W(IN_ADDR_W), .OFS_W(OFS_W),
    .FRAME_PIXELS(FRAME_PIXELS), .DROP_W(DROP_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .addr_axiiv(addr_axiiv), .addr_axiid(addr_axiid),
    .pixel_axiiv(pixel_axiiv), .pixel_axiid(pixel_axiid),
    .axiov(axiov), .addr_axiod(addr_axiod), .pixel_axiod(pixel_axiod),
    .disp_bank(disp_bank), .frame_done(frame_done), .addr_err(addr_err),
    .drop_count(drop_count)
  );

  frame_packager_pp #(
    .PIXEL_W(PIXEL_W), .IN_ADDR_W(IN_ADDR_W), .OFS_W(OFS_W),
    .FRAME_PIXELS(FRAME_PIXELS), .DROP_W(4)
  ) dut_s (
    .clk(clk), .rst_n(rst_n),
    .addr_axiiv(addr_axiiv), .addr_axiid(addr_axiid),
    .pixel_axiiv(pixel_axiiv), .pixel_axiid(pixel_axiid),
    .axiov(s_axiov), .addr_axiod(s_addr_axiod), .pixel_axiod(s_pixel_axiod),
    .disp_bank(s_disp_bank), .frame_done(s_frame_done), .addr_err(s_addr_err),
    .drop_count(s_drop_count)
  );

  function automatic logic [OFS_W:0] ba(input logic b, input int o);
    return {b, OFS_W'(o)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input int a, input logic pv, input logic [7:0] p);
    addr_axiiv  = av;
    addr_axiid  = IN_ADDR_W'(a);
    pixel_axiiv = pv;
    pixel_axiid = p;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 1, 8'h5A);
    repeat (3) cyc();
    n_cmp++;
    if ({axiov, addr_axiod, pixel_axiod, disp_bank, frame_done, addr_err, drop_count} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%b a=%h p=%h db=%b fd=%b ae=%b dc=%0d want all 0",
               axiov, addr_axiod, pixel_axiod, disp_bank, frame_done, addr_err, drop_count);
    end
    n_cmp++;
    if (s_drop_count !== 4'd0) begin
      n_bad++; $display("FAIL reset_sat_count: got %0d want 0", s_drop_count);
    end
    drive(0, 0, 0, 8'h00);
    rst_n = 1'b1;
    exp_drop = 0;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 8'(i + 1));
      cyc();
      exp_drop++;
      n_cmp++;
      if (axiov !== 1'b0) begin
        n_bad++; $display("FAIL basic_drop_v%0d: got %b want 0", i, axiov);
      end
    end
    drive(1, 0, 0, 8'h00);
    cyc();
    n_cmp++;
    if (drop_count !== DROP_W'(3)) begin
      n_bad++; $display("FAIL basic_drop_count: got %0d want 3", drop_count);
    end
    drive(0, 0, 1, 8'hAA);
    cyc();
    got_w = {axiov, addr_axiod, pixel_axiod, frame_done};
    exp_w = {1'b1, ba(0, 0), 8'hAA, 1'b0};
    n_cmp++;
    if (got_w !== exp_w) begin
      n_bad++; $display("FAIL basic_wr0: got %h want %h", got_w, exp_w);
    end
    drive(0, 0, 1, 8'hBB);
    cyc();
    got_w = {axiov, addr_axiod, pixel_axiod, frame_done};
    exp_w = {1'b1, ba(0, 1), 8'hBB, 1'b0};
    n_cmp++;
    if (got_w !== exp_w) begin
      n_bad++; $display("FAIL basic_wr1: got %h want %h", got_w, exp_w);
    end
    drive(0, 0, 0, 8'h00);
    cyc();
    got_w = {axiov, addr_axiod, pixel_axiod, frame_done};
    exp_w = {1'b0, ba(0, 1), 8'hBB, 1'b0};
    n_cmp++;
    if (got_w !== exp_w || drop_count !== DROP_W'(exp_drop)) begin
      n_bad++; $display("FAIL basic_idle_hold: got %h dc=%0d want %h dc=%0d", got_w, drop_count, exp_w, exp_drop);
    end
  endtask

  task automatic test_wrap();
    drive(1, 76798, 0, 8'h00);
    cyc();
    drive(0, 0, 1, 8'h10);
    cyc();
    got_w = {axiov, addr_axiod, pixel_axiod, frame_done};
    exp_w = {1'b1, ba(0, 76798), 8'h10, 1'b0};
    n_cmp++;
    if (got_w !== exp_w) begin
      n_bad++; $display("FAIL wrap_76798: got %h want %h", got_w, exp_w);
    end
    drive(0, 0, 1, 8'h11);
    cyc();
    got_w = {axiov, addr_axiod, pixel_axiod, frame_done};
    exp_w = {1'b1, ba(0, 76799), 8'h11, 1'b1};
    n_cmp++;
    if (got_w !== exp_w || disp_bank !== 1'b0) begin
      n_bad++; $display("FAIL wrap_76799: got %h db=%b want %h db=0", got_w, disp_bank, exp_w);
    end
    drive(0, 0, 1, 8'h12);
    cyc();
    got_w = {axiov, addr_axiod, pixel_axiod, frame_done};
    exp_w = {1'b1, ba(1, 0), 8'h12, 1'b0};
    n_cmp++;
    if (got_w !== exp_w) begin
      n_bad++; $display("FAIL wrap_bank1_0: got %h want %h", got_w, exp_w);
    end
    // Mid-frame header keeps the bank
    drive(1, 10, 1, 8'h13);
    cyc();
    got_w = {axiov, addr_axiod, pixel_axiod, frame_done};
    exp_w = {1'b1, ba(1, 10), 8'h13, 1'b0};
    n_cmp++;
    if (got_w !== exp_w) begin
      n_bad++; $display("FAIL midframe_hdr: got %h want %h", got_w, exp_w);
    end
    drive(1, 76799, 1, 8'h14);
    cyc();
    got_w = {axiov, addr_axiod, pixel_axiod, frame_done};
    exp_w = {1'b1, ba(1, 76799), 8'h14, 1'b1};
    n_cmp++;
    if (got_w !== exp_w || disp_bank !== 1'b1) begin
      n_bad++; $display("FAIL wrap2_last: got %h db=%b want %h db=1", got_w, disp_bank, exp_w);
    end
    drive(0, 0, 1, 8'h15);
    cyc();
    got_w = {axiov, addr_axiod, pixel_axiod, frame_done};
    exp_w = {1'b1, ba(0, 0), 8'h15, 1'b0};
    n_cmp++;
    if (got_w !== exp_w || disp_bank !== 1'b1) begin
      n_bad++; $display("FAIL wrap2_bank0: got %h db=%b want %h db=1", got_w, disp_bank, exp_w);
    end
  endtask

  task automatic test_bad_header();
    drive(1, 76800, 0, 8'h00);
    cyc();
    n_cmp++;
    if ({addr_err, axiov} !== 2'b10) begin
      n_bad++; $display("FAIL bad_hdr_err: got ae=%b v=%b want ae=1 v=0", addr_err, axiov);
    end
    drive(0, 0, 1, 8'h20);
    cyc();
    exp_drop++;
    n_cmp++;
    if ({addr_err, axiov} !== 2'b00) begin
      n_bad++; $display("FAIL bad_hdr_drop0: got ae=%b v=%b want 0 0", addr_err, axiov);
    end
    drive(0, 0, 1, 8'h21);
    cyc();
    exp_drop++;
    n_cmp++;
    if (axiov !== 1'b0 || drop_count !== DROP_W'(exp_drop)) begin
      n_bad++; $display("FAIL bad_hdr_drop1: got v=%b dc=%0d want v=0 dc=%0d", axiov, drop_count, exp_drop);
    end
    drive(1, 50, 0, 8'h00);
    cyc();
    // Header 0x100000 would alias to offset 0 if truncated
    drive(1, 24'h100000, 1, 8'h22);
    cyc();
    exp_drop++;
    n_cmp++;
    if ({addr_err, axiov} !== 2'b10 || drop_count !== DROP_W'(exp_drop)) begin
      n_bad++; $display("FAIL big_hdr_same_px: got ae=%b v=%b dc=%0d want ae=1 v=0 dc=%0d", addr_err, axiov, drop_count, exp_drop);
    end
    drive(0, 0, 1, 8'h23);
    cyc();
    exp_drop++;
    got_w = {axiov, addr_axiod, pixel_axiod, frame_done};
    exp_w = {1'b0, ba(0, 0), 8'h15, 1'b0};
    n_cmp++;
    if (got_w !== exp_w || addr_err !== 1'b0 || drop_count !== DROP_W'(exp_drop)) begin
      n_bad++; $display("FAIL big_hdr_after: got %h ae=%b dc=%0d want %h ae=0 dc=%0d", got_w, addr_err, drop_count, exp_w, exp_drop);
    end
  endtask

  task automatic test_same_cycle();
    drive(1, 5, 1, 8'h55);
    cyc();
    got_w = {axiov, addr_axiod, pixel_axiod, frame_done};
    exp_w = {1'b1, ba(0, 5), 8'h55, 1'b0};
    n_cmp++;
    if (got_w !== exp_w) begin
      n_bad++; $display("FAIL same_cycle_hdr: got %h want %h", got_w, exp_w);
    end
    drive(0, 0, 1, 8'h66);
    cyc();
    got_w = {axiov, addr_axiod, pixel_axiod, frame_done};
    exp_w = {1'b1, ba(0, 6), 8'h66, 1'b0};
    n_cmp++;
    if (got_w !== exp_w) begin
      n_bad++; $display("FAIL same_cycle_next: got %h want %h", got_w, exp_w);
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 76799, 1, 8'h70);
    cyc();
    got_w = {axiov, addr_axiod, pixel_axiod, frame_done};
    exp_w = {1'b1, ba(0, 76799), 8'h70, 1'b1};
    n_cmp++;
    if (got_w !== exp_w) begin
      n_bad++; $display("FAIL rmid_wrap: got %h want %h", got_w, exp_w);
    end
    drive(1, 1000, 1, 8'h71);
    cyc();
    drive(0, 0, 1, 8'h72);
    cyc();
    got_w = {axiov, addr_axiod, pixel_axiod, frame_done};
    exp_w = {1'b1, ba(1, 1001), 8'h72, 1'b0};
    n_cmp++;
    if (got_w !== exp_w) begin
      n_bad++; $display("FAIL rmid_pre: got %h want %h", got_w, exp_w);
    end
    // Assert reset between clock edges; outputs must clear without an edge
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({axiov, addr_axiod, pixel_axiod, disp_bank, frame_done, addr_err, drop_count} !== '0) begin
      n_bad++;
      $display("FAIL rmid_async_clear: got v=%b a=%h p=%h db=%b fd=%b ae=%b dc=%0d want all 0",
               axiov, addr_axiod, pixel_axiod, disp_bank, frame_done, addr_err, drop_count);
    end
    cyc();
    n_cmp++;
    if ({axiov, frame_done, drop_count} !== '0) begin
      n_bad++; $display("FAIL rmid_held: got v=%b fd=%b dc=%0d want 0", axiov, frame_done, drop_count);
    end
    rst_n = 1'b1;
    exp_drop = 0;
    drive(0, 0, 1, 8'h73);
    cyc();
    exp_drop++;
    n_cmp++;
    if (axiov !== 1'b0 || drop_count !== DROP_W'(exp_drop)) begin
      n_bad++; $display("FAIL rmid_post_drop: got v=%b dc=%0d want v=0 dc=%0d", axiov, drop_count, exp_drop);
    end
    drive(1, 0, 1, 8'h74);
    cyc();
    got_w = {axiov, addr_axiod, pixel_axiod, frame_done};
    exp_w = {1'b1, ba(0, 0), 8'h74, 1'b0};
    n_cmp++;
    if (got_w !== exp_w || disp_bank !== 1'b0) begin
      n_bad++; $display("FAIL rmid_bank0: got %h db=%b want %h db=0", got_w, disp_bank, exp_w);
    end
    drive(0, 0, 1, 8'h75);
    cyc();
    got_w = {axiov, addr_axiod, pixel_axiod, frame_done};
    exp_w = {1'b1, ba(0, 1), 8'h75, 1'b0};
    n_cmp++;
    if (got_w !== exp_w) begin
      n_bad++; $display("FAIL rmid_next: got %h want %h", got_w, exp_w);
    end
    drive(0, 0, 0, 8'h00);
  endtask

  task automatic test_saturation();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    exp_drop = 0;
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 1, 8'(i));
      cyc();
      exp_drop++;
      if (i == 13) begin
        n_cmp++;
        if (s_drop_count !== 4'd14) begin
          n_bad++; $display("FAIL sat_before_max: got %0d want 14", s_drop_count);
        end
      end
    end
    n_cmp++;
    if (s_drop_count !== 4'd15) begin
      n_bad++; $display("FAIL sat_hold: got %0d want 15", s_drop_count);
    end
    n_cmp++;
    if (drop_count !== DROP_W'(exp_drop)) begin
      n_bad++; $display("FAIL sat_wide_count: got %0d want %0d", drop_count, exp_drop);
    end
    drive(0, 0, 0, 8'h00);
    cyc();
    n_cmp++;
    if (s_drop_count !== 4'd15 || s_axiov !== 1'b0) begin
      n_bad++; $display("FAIL sat_idle: got dc=%0d v=%b want dc=15 v=0", s_drop_count, s_axiov);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 8'h00);
    test_reset();
    test_basic();
    test_wrap();
    test_bad_header();
    test_same_cycle();
    test_reset_mid();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
